mips_memory: RTL and testbench
==============================

# mips_memory

Unified, byte-addressed, big-endian instruction/data memory that answers the multicycle MIPS core's memory interface (adr, wd, rd, MemWrite). It is the responder side of the core's bus. It replaces ad-hoc behavioural memory models in simulation and in the FPGA top level. It also provides a host word-load port for program/data preload and a streaming dump sequencer for end-of-run memory inspection.

## Interface
**Parameters**
- MEM_BYTES, 128: memory size in bytes; power of two, multiple of 4.
- DUMP_WORDS, MEM_BYTES/4: number of words emitted by one dump.

**Ports**
- clk, in, 1: clock; all state updates on the rising edge.
- RESET, in, 1: synchronous, active-high reset.
- adr, in, 32: core byte address.
- wd, in, 32: core write data.
- MemWrite, in, 1: core write strobe.
- rd, out, 32: read data to the core (registered).
- ld_valid, in, 1: host load request.
- ld_addr, in, 32: host byte address; bits [1:0] are ignored.
- ld_data, in, 32: host load word.
- ld_ready, out, 1: host load accepted this cycle.
- dump_start, in, 1: starts a dump (level-sampled while in IDLE).
- dump_valid, out, 1: dump beat present.
- dump_ready, in, 1: dump beat consumed.
- dump_addr, out, 32: byte address of the dump word.
- dump_data, out, 32: dump word.
- dump_done, out, 1: one-cycle pulse after the last beat is consumed.

## Operation
- Storage is MEM_BYTES bytes. Word at byte address A is {m[A], m[A+1], m[A+2], m[A+3]}, with m[A] as the MSB (big-endian). Every byte index is taken modulo MEM_BYTES, so an unaligned access near the top wraps to byte 0.
- Memory contents are never cleared by RESET. Contents are initialised only through the ld port.
- **Core read:** each cycle, rd <= word(adr). While RESET=1, rd <= word(0) so the core's first fetch after reset sees address 0.
- **Core write:** when MemWrite=1 and RESET=0, word(adr) <= wd at the edge. Reads are read-before-write: rd returns the old data in the write cycle.
- **Host load:** ld_ready = ld_valid & ~MemWrite (combinational). When accepted, word(ld_addr & ~3) <= ld_data. Core writes have priority. Loads are allowed during RESET.
- **Dump FSM** (states IDLE, LOAD, SHOW, DONE):
  - IDLE -> LOAD when dump_start=1. dump_start is ignored in any other state.
  - LOAD: capture word(ptr) into dump_data and ptr into dump_addr; go to SHOW. ptr starts at (DUMP_WORDS-1)*4 and descends, so dumps run highest word first.
  - SHOW: dump_valid=1. On dump_ready: if ptr==0 go to DONE, else ptr -= 4 and go to LOAD. dump_data is a snapshot; a later write to that word does not alter the held beat.
  - DONE: dump_done=1 for one cycle, then return to IDLE.
- **RESET:** FSM -> IDLE, ptr cleared. dump_valid, dump_done, dump_addr and dump_data all become 0. rd becomes word(0) at the next edge.

## Timing
- rd latency is 1 cycle from adr; the core samples rd one edge after driving adr.
- A write is visible to reads on the cycle after the write edge.
- Dump throughput is one beat per 2 cycles (LOAD + SHOW) with dump_ready held high. A full dump of N words takes 2N+1 cycles from start to dump_done.
- A dump beat stays stable while dump_valid=1 and dump_ready=0.
- RESET asserted mid-dump aborts the dump with no dump_done. Memory is unaffected.

## Structure
- Shared package mips_mem_pkg holds:
  - default MEM_BYTES;
  - typedef dump_state_t (IDLE, LOAD, SHOW, DONE);
  - big-endian word pack/unpack functions, reused by the core's test environment.
- One sub-module, mips_mem_dump: the dump FSM plus its pointer. It reads through a dedicated combinational word port of the array.

## Test plan
- **Reset fetch:** load 0x8C010020 at address 0, assert RESET for 2 cycles -> rd=0x8C010020 during and after reset; dump_valid=0.
- **Endianness and read-before-write:** MemWrite with adr=0x24, wd=0x0000000F -> m[0x24..0x27]=00,00,00,0F. rd in the write cycle shows the old value and 0x0000000F on the next cycle.
- **Wrap:** word 0x11223344 written at adr=0x7E -> bytes m[0x7E]=11, m[0x7F]=22, m[0x00]=33, m[0x01]=44.
- **Load collision:** ld_valid with MemWrite=1 -> ld_ready=0 and only the core write lands. On the next cycle with MemWrite=0 -> ld_ready=1 and the load lands.
- **Dump with backpressure:** MEM_BYTES=128 with dump_ready toggling -> 32 beats, addresses 0x7C down to 0x00, data matches the model, then one dump_done pulse. RESET asserted at beat 10 -> immediate IDLE, no dump_done.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and big-endian word helpers for the unified MIPS memory.
package mips_mem_pkg;

    localparam int MEM_BYTES_DEFAULT = 128;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW,
        DONE
    } dump_state_t;

    function automatic logic [31:0] pack_be(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte k of a word in memory order: k=0 is the MSB, stored at the lowest address.
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mips_memory_if.sv
// Core-side memory bus of the multicycle MIPS: the core masters, the memory responds.
interface mips_memory_if;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        MemWrite;

    modport master (output adr, output wd, output MemWrite, input rd);
    modport slave  (input adr, input wd, input MemWrite, output rd);
endinterface

// File: rtl/mips_mem_dump.sv
// Dump sequencer: streams memory words, highest address first, with a valid/ready handshake.
//   state | meaning
//   IDLE  | waiting for dump_start
//   LOAD  | snapshot word(ptr) and ptr into the beat registers
//   SHOW  | beat presented on dump_valid until dump_ready
//   DONE  | one-cycle dump_done pulse after the last beat
module mips_mem_dump
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int DUMP_WORDS = MEM_BYTES / 4
) (
    input  logic                         clk,
    input  logic                         RESET,
    input  logic                         dump_start,
    input  logic                         dump_ready,
    input  logic [31:0]                  word_in,
    output logic [$clog2(MEM_BYTES)-1:0] word_idx,
    output logic                         dump_valid,
    output logic [31:0]                  dump_addr,
    output logic [31:0]                  dump_data,
    output logic                         dump_done
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [31:0] PTR_START = 32'((DUMP_WORDS - 1) * 4);

    dump_state_t state, state_nx;
    logic [31:0] ptr;
    logic        ptr_init, ptr_dec, cap_en;

    always_ff @(posedge clk) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ptr_init = 1'b0;
        ptr_dec  = 1'b0;
        cap_en   = 1'b0;
        case (state)
            IDLE: if (dump_start) begin
                state_nx = LOAD;
                ptr_init = 1'b1;
            end
            LOAD: begin
                cap_en   = 1'b1;
                state_nx = SHOW;
            end
            SHOW: if (dump_ready) begin
                if (ptr == 32'd0) state_nx = DONE;
                else begin
                    ptr_dec  = 1'b1;
                    state_nx = LOAD;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The beat is a snapshot so later core writes cannot disturb a held beat.
    always_ff @(posedge clk) begin
        if (RESET) begin
            ptr       <= '0;
            dump_addr <= '0;
            dump_data <= '0;
        end else begin
            if (ptr_init)     ptr <= PTR_START;
            else if (ptr_dec) ptr <= ptr - 32'd4;
            if (cap_en) begin
                dump_addr <= ptr;
                dump_data <= word_in;
            end
        end
    end

    assign word_idx   = ptr[AW-1:0];
    assign dump_valid = (state == SHOW);
    assign dump_done  = (state == DONE);
endmodule

// File: rtl/mips_memory.sv
// Unified big-endian byte-addressed memory for the multicycle MIPS core,
// with a host word-load port and a streaming dump port.
module mips_memory
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES  = MEM_BYTES_DEFAULT,
    parameter int DUMP_WORDS = MEM_BYTES / 4
) (
    input  logic               clk,
    input  logic               RESET,
    mips_memory_if.slave       bus,
    input  logic               ld_valid,
    input  logic [31:0]        ld_addr,
    input  logic [31:0]        ld_data,
    output logic               ld_ready,
    input  logic               dump_start,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [31:0]        dump_addr,
    output logic [31:0]        dump_data,
    output logic               dump_done
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] rd_base, wr_base, ld_base, dump_base;
    logic [31:0]   rd_word, dump_word;
    logic          core_wr;
    logic          unused_bits;

    // Byte index arithmetic stays in AW bits, so accesses wrap modulo MEM_BYTES.
    function automatic logic [AW-1:0] bi(input logic [AW-1:0] base, input logic [1:0] k);
        return base + AW'(k);
    endfunction

    assign rd_base  = RESET ? '0 : bus.adr[AW-1:0];
    assign wr_base  = bus.adr[AW-1:0];
    assign ld_base  = {ld_addr[AW-1:2], 2'b00};
    assign core_wr  = bus.MemWrite & ~RESET;
    assign ld_ready = ld_valid & ~bus.MemWrite;

    assign rd_word   = pack_be(mem[bi(rd_base, 2'd0)], mem[bi(rd_base, 2'd1)],
                               mem[bi(rd_base, 2'd2)], mem[bi(rd_base, 2'd3)]);
    assign dump_word = pack_be(mem[bi(dump_base, 2'd0)], mem[bi(dump_base, 2'd1)],
                               mem[bi(dump_base, 2'd2)], mem[bi(dump_base, 2'd3)]);

    always_ff @(posedge clk) begin
        if (core_wr) begin
            mem[bi(wr_base, 2'd0)] <= be_byte(bus.wd, 2'd0);
            mem[bi(wr_base, 2'd1)] <= be_byte(bus.wd, 2'd1);
            mem[bi(wr_base, 2'd2)] <= be_byte(bus.wd, 2'd2);
            mem[bi(wr_base, 2'd3)] <= be_byte(bus.wd, 2'd3);
        end else if (ld_ready) begin
            mem[bi(ld_base, 2'd0)] <= be_byte(ld_data, 2'd0);
            mem[bi(ld_base, 2'd1)] <= be_byte(ld_data, 2'd1);
            mem[bi(ld_base, 2'd2)] <= be_byte(ld_data, 2'd2);
            mem[bi(ld_base, 2'd3)] <= be_byte(ld_data, 2'd3);
        end
    end

    always_ff @(posedge clk) begin
        bus.rd <= rd_word;
    end

    mips_mem_dump #(
        .MEM_BYTES  (MEM_BYTES),
        .DUMP_WORDS (DUMP_WORDS)
    ) u_dump (
        .clk        (clk),
        .RESET      (RESET),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .word_in    (dump_word),
        .word_idx   (dump_base),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    assign unused_bits = ^{bus.adr[31:AW], ld_addr[31:AW], ld_addr[1:0]};
endmodule

// File: tb/tb_mips_memory.sv
// Directed bench for mips_memory: reset fetch, endianness, wrap, load collision, dump.
module tb_mips_memory;
    logic        clk = 1'b0;
    logic        RESET;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr, ld_data;
    logic        dump_start, dump_valid, dump_ready, dump_done;
    logic [31:0] dump_addr, dump_data;

    int errors = 0;
    int checks = 0;
    logic [7:0] model [128];

    always #5 clk = ~clk;

    mips_memory_if bus();

    mips_memory #(.MEM_BYTES(128)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .bus        (bus),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    function automatic logic [31:0] mword(input int a);
        logic [6:0] i;
        i = 7'(a);
        return {model[i], model[7'(i + 7'd1)], model[7'(i + 7'd2)], model[7'(i + 7'd3)]};
    endfunction

    task automatic mput(input int a, input logic [31:0] w);
        logic [6:0] i;
        i = 7'(a);
        model[i]             = w[31:24];
        model[7'(i + 7'd1)]  = w[23:16];
        model[7'(i + 7'd2)]  = w[15:8];
        model[7'(i + 7'd3)]  = w[7:0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] w;
        RESET = 1'b1;
        for (int i = 0; i < 32; i++) begin
            w = (i == 0) ? 32'h8C01_0020 : 32'h1000_0000 + 32'(i) * 32'h0001_0203;
            ld_valid = 1'b1;
            ld_addr  = 32'(i * 4);
            ld_data  = w;
            mput(i * 4, w);
            tick;
        end
        ld_valid = 1'b0;
        bus.adr  = 32'h40;
        tick;
        checks++; if (bus.rd !== 32'h8C01_0020) begin errors++; $display("FAIL rd_in_reset_1: got %h want %h", bus.rd, 32'h8C01_0020); end
        tick;
        checks++; if (bus.rd !== 32'h8C01_0020) begin errors++; $display("FAIL rd_in_reset_2: got %h want %h", bus.rd, 32'h8C01_0020); end
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid: got %b want 0", dump_valid); end
        checks++; if (dump_done !== 1'b0) begin errors++; $display("FAIL reset_dump_done: got %b want 0", dump_done); end
        checks++; if (dump_addr !== 32'h0 || dump_data !== 32'h0) begin errors++; $display("FAIL reset_dump_regs: got %h/%h want 0/0", dump_addr, dump_data); end
        RESET   = 1'b0;
        bus.adr = 32'h0;
        tick;
        checks++; if (bus.rd !== 32'h8C01_0020) begin errors++; $display("FAIL rd_after_reset: got %h want %h", bus.rd, 32'h8C01_0020); end
        bus.adr = 32'h4;
        tick;
        checks++; if (bus.rd !== mword(4)) begin errors++; $display("FAIL rd_word4: got %h want %h", bus.rd, mword(4)); end
    endtask

    task automatic test_rbw;
        logic [31:0] old;
        bus.adr = 32'h24;
        tick;
        old = mword(32'h24);
        checks++; if (bus.rd !== old) begin errors++; $display("FAIL rbw_pre: got %h want %h", bus.rd, old); end
        bus.MemWrite = 1'b1;
        bus.wd       = 32'h0000_000F;
        tick;
        mput(32'h24, 32'h0000_000F);
        checks++; if (bus.rd !== old) begin errors++; $display("FAIL rbw_old: got %h want %h", bus.rd, old); end
        bus.MemWrite = 1'b0;
        tick;
        checks++; if (bus.rd !== 32'h0000_000F) begin errors++; $display("FAIL rbw_new: got %h want %h", bus.rd, 32'h0000_000F); end
        bus.adr = 32'h25;
        tick;
        checks++; if (bus.rd !== {24'h00_000F, model[7'h28]}) begin errors++; $display("FAIL be_bytes: got %h want %h", bus.rd, {24'h00_000F, model[7'h28]}); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp;
        bus.adr      = 32'h7E;
        bus.wd       = 32'h1122_3344;
        bus.MemWrite = 1'b1;
        tick;
        bus.MemWrite = 1'b0;
        mput(32'h7E, 32'h1122_3344);
        bus.adr = 32'h7C;
        tick;
        exp = {model[7'h7C], model[7'h7D], 8'h11, 8'h22};
        checks++; if (bus.rd !== exp) begin errors++; $display("FAIL wrap_top: got %h want %h", bus.rd, exp); end
        bus.adr = 32'h0;
        tick;
        exp = {8'h33, 8'h44, model[7'h02], model[7'h03]};
        checks++; if (bus.rd !== exp) begin errors++; $display("FAIL wrap_low: got %h want %h", bus.rd, exp); end
        bus.adr = 32'h7E;
        tick;
        checks++; if (bus.rd !== 32'h1122_3344) begin errors++; $display("FAIL wrap_word: got %h want %h", bus.rd, 32'h1122_3344); end
    endtask

    task automatic test_load_collision;
        logic [31:0] old40;
        old40        = mword(32'h40);
        bus.MemWrite = 1'b1;
        bus.adr      = 32'h30;
        bus.wd       = 32'hCAFE_BABE;
        ld_valid     = 1'b1;
        ld_addr      = 32'h43;
        ld_data      = 32'hDEAD_BEEF;
        #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_blocked: got %b want 0", ld_ready); end
        tick;
        mput(32'h30, 32'hCAFE_BABE);
        bus.MemWrite = 1'b0;
        ld_valid     = 1'b0;
        bus.adr      = 32'h40;
        tick;
        checks++; if (bus.rd !== old40) begin errors++; $display("FAIL collision_no_load: got %h want %h", bus.rd, old40); end
        ld_valid = 1'b1;
        bus.adr  = 32'h30;
        #1;
        checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_free: got %b want 1", ld_ready); end
        tick;
        mput(32'h40, 32'hDEAD_BEEF);
        ld_valid = 1'b0;
        checks++; if (bus.rd !== 32'hCAFE_BABE) begin errors++; $display("FAIL core_write_landed: got %h want %h", bus.rd, 32'hCAFE_BABE); end
        bus.adr = 32'h40;
        tick;
        checks++; if (bus.rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_landed: got %h want %h", bus.rd, 32'hDEAD_BEEF); end
    endtask

    task automatic test_dump_backpressure;
        int beats, cyc, dones;
        logic [31:0] exp_a, exp_d;
        beats = 0; cyc = 0; dones = 0;
        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        while (beats < 32 && cyc < 400) begin
            dump_ready = (cyc % 2) == 1;
            if (dump_done) dones++;
            if (dump_valid) begin
                exp_a = 32'(32'h7C - 32'(beats * 4));
                exp_d = mword(int'(exp_a));
                checks++; if (dump_addr !== exp_a || dump_data !== exp_d) begin errors++; $display("FAIL dump_beat_%0d: got %h/%h want %h/%h", beats, dump_addr, dump_data, exp_a, exp_d); end
                if (dump_ready) beats++;
            end
            tick;
            cyc++;
        end
        dump_ready = 1'b0;
        checks++; if (beats != 32) begin errors++; $display("FAIL dump_beat_count: got %0d want 32", beats); end
        checks++; if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin errors++; $display("FAIL dump_done_pulse: got done=%b valid=%b want 1/0", dump_done, dump_valid); end
        tick;
        checks++; if (dump_done !== 1'b0) begin errors++; $display("FAIL dump_done_single: got %b want 0", dump_done); end
        checks++; if (dones != 0) begin errors++; $display("FAIL dump_done_early: got %0d want 0", dones); end
    endtask

    task automatic test_dump_timing;
        int n;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        n = 1;
        while (!dump_done && n < 200) begin
            tick;
            n++;
        end
        checks++; if (n != 65) begin errors++; $display("FAIL dump_cycles: got %0d want 65", n); end
        tick;
    endtask

    task automatic test_dump_abort;
        int beats, cyc, dones, valids;
        beats = 0; cyc = 0; dones = 0; valids = 0;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick;
        dump_start = 1'b0;
        while (cyc < 100 && !(dump_valid && beats == 10)) begin
            if (dump_valid) beats++;
            tick;
            cyc++;
        end
        checks++; if (dump_valid !== 1'b1 || dump_addr !== 32'h54) begin errors++; $display("FAIL abort_beat10: got valid=%b addr=%h want 1/00000054", dump_valid, dump_addr); end
        RESET = 1'b1;
        tick;
        checks++; if (dump_valid !== 1'b0 || dump_done !== 1'b0) begin errors++; $display("FAIL abort_idle: got valid=%b done=%b want 0/0", dump_valid, dump_done); end
        checks++; if (dump_addr !== 32'h0 || dump_data !== 32'h0) begin errors++; $display("FAIL abort_regs: got %h/%h want 0/0", dump_addr, dump_data); end
        checks++; if (bus.rd !== mword(0)) begin errors++; $display("FAIL abort_rd0: got %h want %h", bus.rd, mword(0)); end
        RESET = 1'b0;
        repeat (80) begin
            if (dump_done) dones++;
            if (dump_valid) valids++;
            tick;
        end
        checks++; if (dones != 0 || valids != 0) begin errors++; $display("FAIL abort_quiet: got done=%0d valid=%0d want 0/0", dones, valids); end
        bus.adr = 32'h7C;
        tick;
        checks++; if (bus.rd !== mword(32'h7C)) begin errors++; $display("FAIL abort_mem_kept: got %h want %h", bus.rd, mword(32'h7C)); end
    endtask

    initial begin
        RESET        = 1'b1;
        bus.adr      = '0;
        bus.wd       = '0;
        bus.MemWrite = 1'b0;
        ld_valid     = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        dump_start   = 1'b0;
        dump_ready   = 1'b0;
        tick;
        test_reset;
        test_rbw;
        test_wrap;
        test_load_collision;
        test_dump_backpressure;
        test_dump_timing;
        test_dump_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "timeout");
    end
endmodule
